// File: rtl/gym_pkg.sv
// Shared types and screen limits for gym movement.
// Direction codes, movement states and the screen-edge helper.
package gym_pkg;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TURN,
    S_WAIT,
    S_STEP
  } mv_state_t;

  localparam int unsigned POS_W     = 10;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned SCR_X_MAX = 639;
  localparam int unsigned SCR_Y_MAX = 479;

  // True when the next pixel in direction d would leave the screen.
  function automatic logic at_edge(
    input dir_t             d,
    input logic [POS_W-1:0] x,
    input logic [POS_W-1:0] y,
    input logic [POS_W-1:0] xmax,
    input logic [POS_W-1:0] ymax
  );
    logic hit;
    hit = 1'b0;
    unique case (d)
      DIR_DOWN:  hit = (y == ymax);
      DIR_UP:    hit = (y == '0);
      DIR_LEFT:  hit = (x == '0);
      DIR_RIGHT: hit = (x == xmax);
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/gym_move_controller.sv
// Player movement sequencer: key -> turn / tile walk, one pixel per clock.
// Optional GYM_MOVE_RUN_EN adds a run input that doubles walk speed.
module gym_move_controller
  import gym_pkg::*;
#(
  parameter int unsigned X_INIT     = 232,
  parameter int unsigned Y_INIT     = 400,
  parameter int unsigned STEP_PX    = 2,
  parameter int unsigned TILE_PX    = 16,
  parameter int unsigned TURN_TICKS = 4,
  parameter int unsigned X_MAX      = SCR_X_MAX,
  parameter int unsigned Y_MAX      = SCR_Y_MAX
) (
`ifdef GYM_MOVE_RUN_EN
  input  logic       run,
`endif
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       key_valid,
  input  logic [1:0] key_dir,
  input  logic       at_bounds,
  output logic [1:0] direction,
  output logic [9:0] charxcurrpos,
  output logic [9:0] charycurrpos,
  output logic       moving,
  output logic [1:0] walk_frame,
  output logic       bump_pulse
);

  mv_state_t        state;
  dir_t             dir_q;
  logic [CNT_W-1:0] turn_cnt;
  logic [CNT_W-1:0] tile_left;
  logic [CNT_W-1:0] px_left;
  logic [CNT_W-1:0] spd;
  logic [CNT_W-1:0] walk_spd;
  logic [POS_W-1:0] nx;
  logic [POS_W-1:0] ny;
  logic             blocked;

`ifdef GYM_MOVE_RUN_EN
  assign walk_spd = run ? CNT_W'(2 * STEP_PX) : CNT_W'(STEP_PX);
`else
  assign walk_spd = CNT_W'(STEP_PX);
`endif

  assign direction = dir_q;

  // Bounds check sees the registered position/direction this cycle.
  always_comb begin
    nx = charxcurrpos;
    ny = charycurrpos;
    unique case (dir_q)
      DIR_DOWN:  ny = charycurrpos + 10'd1;
      DIR_UP:    ny = charycurrpos - 10'd1;
      DIR_LEFT:  nx = charxcurrpos - 10'd1;
      DIR_RIGHT: nx = charxcurrpos + 10'd1;
    endcase
    blocked = at_bounds
            | at_edge(dir_q, charxcurrpos, charycurrpos,
                      POS_W'(X_MAX), POS_W'(Y_MAX));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= S_IDLE;
      dir_q        <= DIR_DOWN;
      charxcurrpos <= POS_W'(X_INIT);
      charycurrpos <= POS_W'(Y_INIT);
      moving       <= 1'b0;
      walk_frame   <= 2'd0;
      bump_pulse   <= 1'b0;
      turn_cnt     <= '0;
      tile_left    <= '0;
      px_left      <= '0;
      spd          <= '0;
    end else begin
      bump_pulse <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (frame_tick && enable && key_valid) begin
            if (dir_t'(key_dir) != dir_q) begin
              dir_q    <= dir_t'(key_dir);
              turn_cnt <= CNT_W'(TURN_TICKS);
              state    <= S_TURN;
            end else begin
              moving     <= 1'b1;
              walk_frame <= walk_frame + 2'd1;
              tile_left  <= CNT_W'(TILE_PX);
              px_left    <= walk_spd;
              spd        <= walk_spd;
              state      <= S_STEP;
            end
          end
        end
        S_TURN: begin
          if (frame_tick) begin
            if (turn_cnt <= CNT_W'(1)) begin
              turn_cnt <= '0;
              state    <= S_IDLE;
            end else begin
              turn_cnt <= turn_cnt - CNT_W'(1);
            end
          end
        end
        S_WAIT: begin
          if (frame_tick) begin
            px_left <= spd;
            state   <= S_STEP;
          end
        end
        S_STEP: begin
          if (blocked) begin
            bump_pulse <= 1'b1;
            moving     <= 1'b0;
            tile_left  <= '0;
            px_left    <= '0;
            state      <= S_IDLE;
          end else begin
            charxcurrpos <= nx;
            charycurrpos <= ny;
            px_left      <= px_left - CNT_W'(1);
            tile_left    <= tile_left - CNT_W'(1);
            if (px_left == CNT_W'(1)) begin
              if (tile_left == CNT_W'(1)) begin
                moving <= 1'b0;
                state  <= S_IDLE;
              end else begin
                state <= S_WAIT;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gym_move_controller.sv
// Bench for gym_move_controller: directed steps plus random walks
// checked against a walk-level position model.
module tb_gym_move_controller;
  import gym_pkg::*;

  localparam int STEP = 2;
  localparam int TILE = 16;
  localparam int TT   = 4;
  localparam int XI   = 232;
  localparam int YI   = 400;
  localparam int GAP  = 7;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       enable = 1'b1;
  logic       key_valid = 1'b0;
  logic [1:0] key_dir = 2'd0;
  logic       at_bounds;
  logic [1:0] direction;
  logic [9:0] charxcurrpos;
  logic [9:0] charycurrpos;
  logic       moving;
  logic [1:0] walk_frame;
  logic       bump_pulse;
`ifdef GYM_MOVE_RUN_EN
  logic       run = 1'b0;
`endif

  logic       blk_en = 1'b0;
  logic [1:0] blk_dir = 2'd0;
  logic [9:0] blk_x = '0;
  logic [9:0] blk_y = '0;

  int checks = 0;
  int errors = 0;
  int bumps  = 0;

  int mx, my, mdir, mframe, mbumps;

  gym_move_controller dut (
`ifdef GYM_MOVE_RUN_EN
    .run          (run),
`endif
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_tick   (frame_tick),
    .enable       (enable),
    .key_valid    (key_valid),
    .key_dir      (key_dir),
    .at_bounds    (at_bounds),
    .direction    (direction),
    .charxcurrpos (charxcurrpos),
    .charycurrpos (charycurrpos),
    .moving       (moving),
    .walk_frame   (walk_frame),
    .bump_pulse   (bump_pulse)
  );

  always #5 Clk = ~Clk;

  assign at_bounds = blk_en && (direction == blk_dir)
                  && (charxcurrpos == blk_x)
                  && (charycurrpos == blk_y);

  always @(negedge Clk) if (bump_pulse) bumps++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit key, input int d);
    @(negedge Clk);
    key_valid  = key;
    key_dir    = 2'(d);
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    key_valid  = 1'b0;
    repeat (GAP) @(negedge Clk);
  endtask

  task automatic model_reset();
    mx = XI; my = YI; mdir = 0; mframe = 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_x"}, 32'(charxcurrpos), 32'(mx));
    chk({tag, "_y"}, 32'(charycurrpos), 32'(my));
    chk({tag, "_dir"}, 32'(direction), 32'(mdir));
    chk({tag, "_moving"}, 32'(moving), 32'd0);
    chk({tag, "_frame"}, 32'(walk_frame), 32'(mframe));
    chk({tag, "_bumps"}, 32'(bumps), 32'(mbumps));
  endtask

  // A whole tile walk: stops at the first pixel that is off-screen or flagged.
  task automatic model_walk();
    bit hit;
    mframe = (mframe + 1) % 4;
    for (int k = 0; k < TILE; k++) begin
      hit = (mdir == 0 && my == SCR_Y_MAX) || (mdir == 1 && my == 0)
         || (mdir == 2 && mx == 0) || (mdir == 3 && mx == SCR_X_MAX)
         || (blk_en && blk_dir == 2'(mdir) && mx == blk_x && my == blk_y);
      if (hit) begin
        mbumps++;
        return;
      end
      case (mdir)
        0: my++;
        1: my--;
        2: mx--;
        default: mx++;
      endcase
    end
  endtask

  task automatic turn_to(input int d);
    if (d != mdir) begin
      tick(1'b1, d);
      mdir = d;
      chk("turn_dir", 32'(direction), 32'(d));
      repeat (TT) tick(1'b0, 0);
    end
  endtask

  task automatic walk(input int d, input string tag);
    turn_to(d);
    model_walk();
    tick(1'b1, d);
    repeat (TILE / STEP) tick(1'b0, 0);
    chk_all(tag);
  endtask

  initial begin
    int ys, off, d;
    mbumps = 0;
    model_reset();
    repeat (3) @(negedge Clk);
    chk_all("reset");
    chk("reset_bump", 32'(bump_pulse), 32'd0);
    Reset_n = 1'b1;

    repeat (10) tick(1'b0, 0);
    chk_all("idle10");

    enable = 1'b0;
    tick(1'b1, 1);
    chk("disabled_dir", 32'(direction), 32'd0);
    enable = 1'b1;

    tick(1'b1, 1);
    chk("turn_dir1", 32'(direction), 32'd1);
    chk("turn_y", 32'(charycurrpos), 32'(YI));
    mdir = 1;
    for (int i = 1; i <= TT; i++) begin
      tick(1'b1, 1);
      chk("turn_hold_moving", 32'(moving), 32'd0);
      chk("turn_hold_y", 32'(charycurrpos), 32'(YI));
    end

    for (int k = 1; k <= TILE / STEP; k++) begin
      tick(k == 1, 1);
      chk("walk_y", 32'(charycurrpos), 32'(YI - STEP * k));
      chk("walk_moving", 32'(moving), 32'(k < TILE / STEP));
      chk("walk_frame", 32'(walk_frame), 32'd1);
    end
    my = YI - TILE; mframe = 1;

    tick(1'b1, 1);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst");
    @(negedge Clk);
    Reset_n = 1'b1;

    blk_en = 1'b1; blk_dir = 2'd1; blk_x = 10'(XI); blk_y = 10'd390;
    walk(1, "blocked390");
    chk("blocked_y", 32'(charycurrpos), 32'd390);
    blk_en = 1'b0;

    for (int n = 0; n < 12; n++) begin
      d   = int'($urandom_range(0, 3));
      off = int'($urandom_range(0, 20));
      blk_en  = ($urandom_range(0, 1) == 1);
      blk_dir = 2'(d);
      blk_x = 10'(mx); blk_y = 10'(my);
      case (d)
        0: blk_y = 10'(my + off);
        1: blk_y = 10'(my - off);
        2: blk_x = 10'(mx - off);
        default: blk_x = 10'(mx + off);
      endcase
      walk(d, "rand");
    end
    blk_en = 1'b0;

    while (mx > 0) walk(2, "left");
    walk(2, "left_edge");
    chk("left_edge_x", 32'(charxcurrpos), 32'd0);

`ifdef GYM_MOVE_RUN_EN
    turn_to(1);
    ys = my;
    run = 1'b1;
    for (int k = 1; k <= TILE / (2 * STEP); k++) begin
      tick(k == 1, 1);
      if (k == 2) run = ~run;
      chk("run_y", 32'(charycurrpos), 32'(ys - 2 * STEP * k));
      chk("run_moving", 32'(moving), 32'(k < TILE / (2 * STEP)));
    end
    run = 1'b0;
    my = ys - TILE; mframe = (mframe + 1) % 4;
    chk_all("run_end");
`else
    ys = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gym_move_controller.md
Name: gym_move_controller

Overview:
Sequences player movement inside the gym map. It turns held direction keys into tile-sized walks, advancing one pixel per clock cycle on each frame tick. Before every pixel it consults the external gym bounds checker, which is combinational on this block's registered direction and position outputs. Sits between the keyboard decoder and the sprite/renderer, and owns the authoritative character position.

Parameters:
X_INIT, 232, reset x position (pixels)
Y_INIT, 400, reset y position (pixels)
STEP_PX, 2, pixels advanced per frame tick while walking
TILE_PX, 16, pixels per walk; must be a multiple of STEP_PX
TURN_TICKS, 4, frame ticks spent in a turn-in-place
X_MAX, 639, right screen limit
Y_MAX, 479, bottom screen limit

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per video frame
enable  in  1  movement permitted (low during menus/battle)
key_valid  in  1  a direction key is held
key_dir  in  2  held key: 0 down, 1 up, 2 left, 3 right
at_bounds  in  1  bounds checker result for current direction/charxcurrpos/charycurrpos
direction  out  2  facing direction; drives the bounds checker and sprite select
charxcurrpos  out  10  character x
charycurrpos  out  10  character y
moving  out  1  high from walk start until the walk ends
walk_frame  out  2  animation phase; increments at each walk start, wraps 3->0
bump_pulse  out  1  one-cycle pulse when a step is blocked

Behaviour:
- Single clock domain. Clk is the only clock.
- Reset_n low (asynchronous): pos = (X_INIT, Y_INIT), direction = 0, moving = 0, walk_frame = 0, bump_pulse = 0, all counters 0, state IDLE.
- States: IDLE, TURN, WAIT, STEP.
- IDLE: acts only on a cycle where frame_tick & enable & key_valid.
  - key_dir != direction: latch direction = key_dir, load turn_cnt = TURN_TICKS, go TURN.
  - key_dir == direction: moving = 1, walk_frame += 1, tile_left = TILE_PX, px_left = STEP_PX, go STEP.
- TURN: turn_cnt decrements on each frame_tick. Leaving TURN at 0 goes to IDLE. The position never changes in TURN.
- STEP: one pixel per Clk cycle.
  - A step is blocked if at_bounds = 1, or if the next pixel would leave 0..X_MAX / 0..Y_MAX.
  - Blocked: no move; bump_pulse = 1 for one cycle; moving = 0; go IDLE. The remainder of the walk is abandoned.
  - Not blocked: move 1 px (down y+1, up y-1, left x-1, right x+1); decrement px_left and tile_left.
  - When px_left reaches 0: go IDLE if tile_left is 0 (moving = 0), otherwise go WAIT.
- WAIT: on frame_tick, set px_left = STEP_PX and go STEP.
- The bounds check is applied in the same cycle, against the registered outputs. There is no pipeline bubble.
- key_dir/key_valid changes during TURN/WAIT/STEP are ignored. The walk always completes unless blocked.
- enable low: only prevents leaving IDLE. An in-flight turn or walk finishes.
- frame_tick arriving during STEP is ignored; STEP_PX cycles are far shorter than a frame.
- Positions are unsigned 10-bit. The screen-limit check prevents wrap below 0.

Optional Feature:
GYM_MOVE_RUN_EN
- Defined: adds input port run (1 bit), sampled at walk start. When run = 1, per-tick pixels become 2*STEP_PX for that whole walk.
- Undefined: no run port; speed is always STEP_PX.

Decomposition:
- Shared package gym_pkg:
  - dir_t enum: DIR_DOWN = 0, DIR_UP = 1, DIR_LEFT = 2, DIR_RIGHT = 3.
  - Screen-limit constants.
  - Movement state enum.
- No sub-module. The gym bounds checker stays external, so other maps can reuse this controller with their own checker.

Test Plan:
- Reset release -> pos (232,400), direction 0, moving 0, walk_frame 0; hold 10 ticks without keys -> unchanged.
- Facing down, key up held, one tick -> direction 1 within 1 cycle, pos unchanged, IDLE after 4 further ticks; next tick starts a walk.
- Facing up, at_bounds = 0, key up held -> y 400->384 over 8 ticks, 2 px per tick; moving high throughout; walk_frame = 1.
- Bench drives at_bounds = 1 when y == 390 and direction 1 -> y stops at 390; bump_pulse for exactly one cycle; moving 0 next cycle.
- pos x = 0 facing left, key left -> no move, bump_pulse; Reset_n low mid-walk -> outputs back to reset values asynchronously.
- GYM_MOVE_RUN_EN defined, run = 1 -> y 400->384 in 4 ticks at 4 px per tick; run toggled mid-walk -> speed unchanged.
